// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned N x N -> 2N shift-add multiplier, one multiplier bit per cycle.
// Includes the N-bit ripple adder that sums the partial-product high half with the multiplicand.

module rippleAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] S,
    output logic         Cout
);
    logic carry;

    always_comb begin
        S     = '0;
        carry = 1'b0;
        for (int unsigned i = 0; i < unsigned'(N); i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end
endmodule

module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           Start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic           Busy,
    output logic           Done,
    output logic [2*N-1:0] P
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  m;
    logic [N-1:0]  hi;
    logic [N-1:0]  lo;
    logic [N-1:0]  sum;
    logic          cout;

    rippleAdder #(.N(N)) adder_u (
        .A    (hi),
        .B    (lo[0] ? m : '0),
        .S    (sum),
        .Cout (cout)
    );

    assign P = {hi, lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            count <= '0;
            m     <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        m     <= A;
                        hi    <= '0;
                        lo    <= B;
                        count <= CW'(N);
                        state <= RUN;
                        Busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Carry-out becomes the new HI MSB; the consumed multiplier bit falls off LO.
                    {hi, lo} <= {cout, sum, lo[N-1:1]};
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
